i2c_master_byte: RTL and testbench



---
 rtl/i2c_master_byte.sv | 196 +++++++++++++++++++
 tb/tb_i2c_master_byte.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_byte.sv
// ============================================================================
// Module   : i2c_master_byte
// Brief    : Single-byte I2C master: START, address+R/W, one data byte, STOP.
//            Optional SCL clock stretching when CLOCK_STRETCH_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_master_byte #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       RW,
    input  logic [6:0] slaveAdd,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       ackerror,
    output logic [7:0] data_out,
    output logic       done,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    localparam int             CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WRITE, S_WACK, S_READ, S_MNACK, S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rd_q, rd_d;
    logic [7:0]       dout_q, dout_d;
    logic             rw_q, rw_d;
    logic             ackerr_q, ackerr_d;
    logic             done_q, done_d;
    logic             stall;
    logic             tick;

`ifdef CLOCK_STRETCH_EN
    // SCL has been released in Q2; a slave holding it low freezes the slot.
    assign stall = (state_q != S_IDLE) && (phase_q == 2'd2) && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stall      = 1'b0;
`endif

    assign tick = (cnt_q == CNT_MAX) && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            phase_q  <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            dout_q   <= '0;
            rw_q     <= 1'b0;
            ackerr_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            dout_q   <= dout_d;
            rw_q     <= rw_d;
            ackerr_q <= ackerr_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        dout_d   = dout_q;
        rw_d     = rw_q;
        ackerr_d = ackerr_q;
        done_d   = 1'b0;

        if (state_q == S_IDLE) begin
            cnt_d   = '0;
            phase_d = '0;
            bit_d   = '0;
            if (enable) begin
                sh_d     = {slaveAdd, RW};
                rw_d     = RW;
                wdata_d  = data_in;
                ackerr_d = 1'b0;
                state_d  = S_START;
            end
        end else begin
            if (!stall) begin
                cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
            end
            if (tick) begin
                phase_d = phase_q + 2'd1;
                case (state_q)
                    S_START: if (phase_q == 2'd3) state_d = S_ADDR;
                    S_ADDR, S_WRITE: begin
                        if (phase_q == 2'd3) begin
                            sh_d  = {sh_q[6:0], 1'b0};
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
                            end
                        end
                    end
                    S_AACK: begin
                        if (phase_q == 2'd2 && sda_i) ackerr_d = 1'b1;
                        if (phase_q == 2'd3) begin
                            if (ackerr_q)  state_d = S_STOP;
                            else if (rw_q) state_d = S_READ;
                            else begin
                                state_d = S_WRITE;
                                sh_d    = wdata_q;
                            end
                        end
                    end
                    S_WACK: begin
                        if (phase_q == 2'd2 && sda_i) ackerr_d = 1'b1;
                        if (phase_q == 2'd3) state_d = S_STOP;
                    end
                    S_READ: begin
                        if (phase_q == 2'd2) rd_d = {rd_q[6:0], sda_i};
                        if (phase_q == 2'd3) begin
                            bit_d = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                dout_d  = rd_q;
                                state_d = S_MNACK;
                            end
                        end
                    end
                    S_MNACK: if (phase_q == 2'd3) state_d = S_STOP;
                    S_STOP: begin
                        if (phase_q == 2'd3) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Pad controls decode purely from registered state so reset clears them at once.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            S_START: sda_oe = phase_q[1];
            S_ADDR, S_WRITE: begin
                scl_oe = !phase_q[1];
                sda_oe = !sh_q[7];
            end
            S_AACK, S_WACK, S_READ, S_MNACK: scl_oe = !phase_q[1];
            S_STOP: begin
                scl_oe = !phase_q[1];
                sda_oe = (phase_q != 2'd3);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign ackerror = ackerr_q;
    assign data_out = dout_q;
    assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_byte.sv
// ============================================================================
// Module   : tb_i2c_master_byte
// Brief    : Randomized self-checking bench for i2c_master_byte with a
//            behavioural open-drain slave and transaction-level reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_master_byte;

    localparam int C_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       RW;
    logic [6:0] slaveAdd;
    logic [7:0] data_in;
    logic       busy, ackerror, done, scl_oe, sda_oe;
    logic [7:0] data_out;
    logic       scl_i, sda_i;

    // Slave configuration for the current transaction
    logic       s_rw;
    logic       s_nack_addr;
    logic       s_nack_data;
    logic [7:0] s_rdata;
    logic       pull;

    int         k;
    logic       scl_prev;
    logic       obs[$];
    logic       exp_q[$];

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] m_last_read;

    always #5 clk = ~clk;

    i2c_master_byte #(.CLK_DIV(C_DIV)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .RW       (RW),
        .slaveAdd (slaveAdd),
        .data_in  (data_in),
        .busy     (busy),
        .ackerror (ackerror),
        .data_out (data_out),
        .done     (done),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .scl_i    (scl_i),
        .sda_i    (sda_i)
    );

    // Slot k counts SCL falls: 1..8 address, 9 ack, 10..17 data, 18 ack.
    always_comb begin
        pull = 1'b0;
        if (busy && !s_nack_addr) begin
            if (k == 9) pull = 1'b1;
            else if (s_rw && k >= 10 && k <= 17) pull = !s_rdata[17 - k];
            else if (!s_rw && k == 18 && !s_nack_data) pull = 1'b1;
        end
    end

    assign scl_i = !scl_oe;
    assign sda_i = !(sda_oe || pull);

    always @(negedge clk) begin
        if (!busy) k <= 0;
        else if (scl_oe && !scl_prev) k <= k + 1;
        if (busy && !scl_oe && scl_prev) obs.push_back(sda_i);
        scl_prev <= scl_oe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           input logic [7:0] rd, input logic na, input logic nd,
                           input bit pulse);
        int   busy_cyc = 0;
        int   done_cnt = 0;
        int   after    = -1;
        logic exp_ack;

        exp_q.delete();
        for (int i = 6; i >= 0; i--) exp_q.push_back(a[i]);
        exp_q.push_back(r);
        exp_q.push_back(na);
        if (!na) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(r ? rd[i] : wd[i]);
            exp_q.push_back(r ? 1'b1 : nd);
        end
        exp_q.push_back(1'b0);
        exp_ack = na || (!r && nd);
        if (!na && r) m_last_read = rd;

        s_rw = r; s_nack_addr = na; s_nack_data = nd; s_rdata = rd;
        obs.delete();
        @(negedge clk);
        slaveAdd = a; RW = r; data_in = wd; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            enable = (pulse && (cyc == 37 || cyc == 150)) ? 1'b1 : 1'b0;
            if (done_cnt > 0 && after < 0) after = cyc;
            if (after >= 0 && cyc >= after + 8) break;
            @(negedge clk);
        end
        enable = 1'b0;
        check("busy_cycles", busy_cyc, (na ? 44 : 80) * C_DIV);
        check("done_pulses", done_cnt, 1);
        check("ackerror", ackerror, exp_ack);
        check("data_out", data_out, m_last_read);
        check("busy_after", busy, 0);
        check("sda_bits_len", obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            check($sformatf("sda_bit%0d", i), obs[i], exp_q[i]);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; RW = 1'b0; slaveAdd = '0; data_in = '0;
        s_rw = 1'b0; s_nack_addr = 1'b0; s_nack_data = 1'b0; s_rdata = '0;
        m_last_read = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_done", done, 0);
        check("rst_data_out", data_out, 0);
        check("rst_ackerror", ackerror, 0);
        rst = 1'b0;

        run_txn(7'h36, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
        run_txn(7'h36, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_txn(7'h36, 1'b1, 8'h00, 8'h99, 1'b1, 1'b0, 1'b0);
        run_txn(7'h12, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);
        run_txn(7'h12, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset while the address byte is on the bus
        s_rw = 1'b0; s_nack_addr = 1'b0; s_nack_data = 1'b0;
        @(negedge clk);
        slaveAdd = 7'h55; RW = 1'b0; data_in = 8'h0F; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int cyc = 0; cyc < 500 && k != 4; cyc++) @(negedge clk);
        check("reach_addr_bit3", k, 4);
        #1 rst = 1'b1;
        #1;
        m_last_read = '0;
        check("midrst_scl_oe", scl_oe, 0);
        check("midrst_sda_oe", sda_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ackerror", ackerror, 0);
        check("midrst_data_out", data_out, 0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(7'h2B, 1'b0, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 16; t++) begin
            run_txn(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
